// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill controller.
// Provides the controller state encoding, derived address-field widths
// and the size of the backing instruction memory.
package icache_refill_ctrl_pkg;

  // Word address width seen by fetch and by the instruction memory.
  localparam int unsigned ADDR_W = 30;

  // Number of words implemented in the instruction memory; addresses at
  // or above this read as zero and are still cached normally.
  localparam int unsigned INST_MEM_WORDS = 4096;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

  // Word-offset field width inside a line.
  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Set-index field width.
  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Tag field width: whatever is left of the word address.
  function automatic int unsigned tag_w(input int unsigned line_words,
                                        input int unsigned sets);
    return ADDR_W - off_w(line_words) - idx_w(sets);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Instruction-cache data array: SETS lines of LINE_WORDS 32-bit words.
// Ports:
//   clk, rst          clock and synchronous active-high reset (read register only)
//   wr_en/idx/off/data one write port used by the refill sequencer
//   rd_en/idx/off     read request; rd_data is registered and holds when rd_en=0
module icache_line_store
  import icache_refill_ctrl_pkg::*;
#(
  parameter  int unsigned LINE_WORDS = 4,
  parameter  int unsigned SETS       = 16,
  localparam int unsigned OFF_W      = off_w(LINE_WORDS),
  localparam int unsigned IDX_W      = idx_w(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic [31:0]      rd_data
);

  logic [31:0] data_r [SETS][LINE_WORDS];
  logic [31:0] rd_data_r;

  // Line storage write port; contents need no reset since valid bits guard them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_r[wr_idx][wr_off] <= wr_data;
    end
  end

  // Registered read port; output holds its last value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= 32'h0000_0000;
    end else if (rd_en) begin
      rd_data_r <= data_r[rd_idx][rd_off];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache controller between RV32I fetch and a
// word-addressed instruction memory with 1-cycle synchronous read.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   fetch_en, fetch_addr  fetch request (word address)
//   fetch_data            instruction of the previous cycle's accepted hit
//   fetch_stall           core must hold its request
//   flush                 one-cycle pulse invalidating every line
//   mem_addr, mem_data    instruction memory read port
//   hit_cnt, miss_cnt     wrapping performance counters
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic [29:0] fetch_addr,
  output logic [31:0] fetch_data,
  output logic        fetch_stall,
  input  logic        flush,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned OFF_W = off_w(LINE_WORDS);
  localparam int unsigned IDX_W = idx_w(SETS);
  localparam int unsigned TAG_W = tag_w(LINE_WORDS, SETS);
  localparam int unsigned CNT_W = OFF_W + 1;

  state_t             state_r;
  logic [SETS-1:0]    valid_r;
  logic [TAG_W-1:0]   tag_r [SETS];
  logic [ADDR_W-1:0]  base_r;
  logic [CNT_W-1:0]   req_cnt_r;
  logic [OFF_W-1:0]   rsp_cnt_r;
  logic               rsp_active_r;
  logic               flush_pend_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [31:0]        hit_cnt_r;
  logic [31:0]        miss_cnt_r;

  logic [OFF_W-1:0]   off_s;
  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic               hit_s;
  logic               miss_s;
  logic [ADDR_W-1:0]  line_base_s;
  logic [IDX_W-1:0]   refill_idx_s;
  logic               line_we_s;
  logic               last_s;

  assign off_s        = fetch_addr[OFF_W-1:0];
  assign idx_s        = fetch_addr[OFF_W +: IDX_W];
  assign tag_s        = fetch_addr[ADDR_W-1 -: TAG_W];
  assign hit_s        = (state_r == ST_IDLE) & fetch_en & valid_r[idx_s] & (tag_r[idx_s] == tag_s);
  assign miss_s       = (state_r == ST_IDLE) & fetch_en & ~hit_s;
  assign fetch_stall  = (state_r != ST_IDLE) | (fetch_en & ~hit_s);
  assign line_base_s  = {fetch_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign refill_idx_s = base_r[OFF_W +: IDX_W];
  // Responses trail requests by one cycle, so writes start on the second REFILL cycle.
  assign line_we_s    = (state_r == ST_REFILL) & rsp_active_r;
  assign last_s       = line_we_s & (rsp_cnt_r == OFF_W'(LINE_WORDS - 1));

  // Controller FSM, refill sequencing, valid bits and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      valid_r      <= '0;
      base_r       <= '0;
      req_cnt_r    <= '0;
      rsp_cnt_r    <= '0;
      rsp_active_r <= 1'b0;
      flush_pend_r <= 1'b0;
      mem_addr_r   <= '0;
      hit_cnt_r    <= 32'd0;
      miss_cnt_r   <= 32'd0;
    end else begin
      if (hit_s) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (flush) begin
            valid_r <= '0;
          end
          if (miss_s) begin
            base_r       <= line_base_s;
            // mem_addr is registered, so word 0 is issued at the miss edge
            // and is on the bus during the first REFILL cycle.
            mem_addr_r   <= line_base_s;
            req_cnt_r    <= CNT_W'(1);
            rsp_cnt_r    <= '0;
            rsp_active_r <= 1'b0;
            miss_cnt_r   <= miss_cnt_r + 32'd1;
            state_r      <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (flush) begin
            flush_pend_r <= 1'b1;
          end
          if (req_cnt_r < CNT_W'(LINE_WORDS)) begin
            mem_addr_r <= base_r + ADDR_W'(req_cnt_r);
            req_cnt_r  <= req_cnt_r + CNT_W'(1);
          end
          rsp_active_r <= 1'b1;
          if (line_we_s) begin
            rsp_cnt_r <= rsp_cnt_r + OFF_W'(1);
            if (last_s) begin
              // A flush seen at any point of the refill, including its last
              // cycle, leaves the freshly filled line invalid.
              valid_r[refill_idx_s] <= ~(flush_pend_r | flush);
              flush_pend_r          <= 1'b0;
              state_r               <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag capture at refill completion; the old tag of the set is overwritten.
  always_ff @(posedge clk) begin
    if (!rst && last_s) begin
      tag_r[refill_idx_s] <= base_r[ADDR_W-1 -: TAG_W];
    end
  end

  icache_line_store #(
    .LINE_WORDS (LINE_WORDS),
    .SETS       (SETS)
  ) u_line_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (line_we_s),
    .wr_idx  (refill_idx_s),
    .wr_off  (rsp_cnt_r),
    .wr_data (mem_data),
    .rd_en   (hit_s),
    .rd_idx  (idx_s),
    .rd_off  (off_s),
    .rd_data (fetch_data)
  );

  assign mem_addr = mem_addr_r;
  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl (LINE_WORDS=4, SETS=16).
// The reference model is transaction level: a set of valid/tag entries and
// the rule that any cached word equals the memory word at its address.
module tb_icache_refill_ctrl;

  localparam int LW   = 4;
  localparam int NSET = 16;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [29:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_stall;
  logic        flush;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_cmp;
  int n_fail;

  logic        m_valid [NSET];
  logic [23:0] m_tag   [NSET];
  logic [31:0] m_hit;
  logic [31:0] m_miss;
  logic [31:0] exp_fd;

  icache_refill_ctrl #(.LINE_WORDS(LW), .SETS(NSET)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_stall (fetch_stall),
    .flush       (flush),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: word i holds 0x1000_0000 + i; beyond 4096 words reads 0.
  function automatic logic [31:0] memf(input logic [29:0] a);
    if (a < 30'd4096) return 32'h1000_0000 + 32'(a);
    else return 32'h0000_0000;
  endfunction

  // Memory with 1-cycle synchronous read.
  always @(posedge clk) mem_data <= memf(mem_addr);

  function automatic logic m_lookup(input logic [29:0] a);
    return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[29:6]);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NSET; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sample of the registered outputs against the model.
  task automatic sample();
    @(negedge clk);
    chk("fetch_data", fetch_data, exp_fd);
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
  endtask

  task automatic idle(input int n);
    fetch_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      sample();
      chk("idle_stall", 32'(fetch_stall), 32'd0);
      tick();
    end
  endtask

  task automatic pulse_flush();
    fetch_en = 1'b0;
    flush    = 1'b1;
    sample();
    chk("flush_stall", 32'(fetch_stall), 32'd0);
    tick();
    flush = 1'b0;
    clear_model();
  endtask

  // One fetch until it is accepted. fl_in: -1 none, 0 flush in the first
  // request cycle, k=1..LW+1 flush on REFILL cycle k of the first refill.
  task automatic fetch(input logic [29:0] a, input int fl_in);
    int          fl;
    logic        done;
    logic        lost;
    logic [29:0] base;
    fl   = fl_in;
    done = 1'b0;
    base = {a[29:2], 2'b00};
    fetch_en   = 1'b1;
    fetch_addr = a;
    while (!done) begin
      if (m_lookup(a)) begin
        flush = (fl == 0);
        sample();
        chk("hit_stall", 32'(fetch_stall), 32'd0);
        tick();
        flush  = 1'b0;
        m_hit  = m_hit + 32'd1;
        exp_fd = memf(a);
        if (fl == 0) clear_model();
        done = 1'b1;
      end else begin
        flush = (fl == 0);
        sample();
        chk("miss_stall", 32'(fetch_stall), 32'd1);
        tick();
        m_miss = m_miss + 32'd1;
        if (fl == 0) clear_model();
        lost = 1'b0;
        for (int k = 1; k <= LW + 1; k++) begin
          flush = (fl == k);
          sample();
          chk("refill_stall", 32'(fetch_stall), 32'd1);
          if (k <= LW) chk("refill_addr", 32'(mem_addr), 32'(base + 30'(k - 1)));
          tick();
          if (fl == k) lost = 1'b1;
        end
        flush = 1'b0;
        m_tag[a[5:2]]   = a[29:6];
        m_valid[a[5:2]] = !lost;
      end
      fl = -1;
    end
  endtask

  // Hard time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] a;
    int          tsel;
    int          fl;
    n_cmp  = 0;
    n_fail = 0;
    m_hit  = 32'd0;
    m_miss = 32'd0;
    exp_fd = 32'd0;
    clear_model();
    rst        = 1'b1;
    fetch_en   = 1'b0;
    fetch_addr = 30'd0;
    flush      = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    sample();
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd0);
    tick();

    // Cold miss, then sequential hits in the same line
    fetch(30'h000, -1);
    fetch(30'h001, -1);
    fetch(30'h002, -1);
    fetch(30'h003, -1);
    idle(1);

    // Conflict on set 0, then the old line misses again
    fetch(30'h040, -1);
    fetch(30'h000, -1);
    idle(1);

    // Flush in IDLE forces a new refill
    fetch(30'h040, -1);
    pulse_flush();
    fetch(30'h040, -1);

    // Hit coinciding with a flush still returns data; the line is then gone
    fetch(30'h041, 0);
    fetch(30'h042, -1);

    // Flush on REFILL cycle 2: line left invalid, second refill follows
    fetch(30'h080, 2);
    fetch(30'h081, -1);
    idle(1);

    // Reset on REFILL cycle 3
    pulse_flush();
    fetch_en   = 1'b1;
    fetch_addr = 30'h000;
    sample();
    chk("rstr_stall0", 32'(fetch_stall), 32'd1);
    tick();
    m_miss = m_miss + 32'd1;
    repeat (2) begin
      sample();
      chk("rstr_stall", 32'(fetch_stall), 32'd1);
      tick();
    end
    rst = 1'b1;
    sample();
    tick();
    rst    = 1'b0;
    clear_model();
    m_hit  = 32'd0;
    m_miss = 32'd0;
    exp_fd = 32'd0;
    fetch_en = 1'b0;
    sample();
    chk("rstr_idle_stall", 32'(fetch_stall), 32'd0);
    chk("rstr_mem_addr", 32'(mem_addr), 32'd0);
    tick();
    fetch(30'h000, -1);
    fetch(30'h003, -1);

    // Randomized traffic over a few sets, including out-of-range tags
    for (int i = 0; i < 80; i++) begin
      tsel = $urandom_range(0, 3);
      a[29:6] = (tsel == 3) ? 24'hFF_FFFF : 24'(tsel);
      a[5:2]  = 4'($urandom_range(0, 3));
      a[1:0]  = 2'($urandom_range(0, 3));
      fl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, LW + 1) : -1;
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      fetch(a, fl);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Direct-mapped instruction cache controller between the RV32I fetch stage and the word-addressed instruction memory.
- Holds tag, valid and line storage internally. On a miss it stalls fetch and sequences a full-line refill from the memory, which has a 1-cycle synchronous read.
- Also supports a whole-cache flush after debug writes to instruction memory, and keeps hit/miss performance counters.

Parameters:
- LINE_WORDS, 4, words per line; power of 2, at least 2; OFF_W = log2(LINE_WORDS).
- SETS, 16, number of lines; power of 2; IDX_W = log2(SETS).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  core requests the instruction at fetch_addr this cycle.
- fetch_addr  in  30  word address [31:2].
- fetch_data  out  32  instruction for the previous cycle's accepted hit.
- fetch_stall  out  1  core must hold fetch_addr and fetch_en.
- flush  in  1  one-cycle pulse; invalidate all lines.
- mem_addr  out  30  word address [31:2] to instruction memory.
- mem_data  in  32  memory read data, valid 1 cycle after mem_addr.
- hit_cnt  out  32  accepted hits, wraps.
- miss_cnt  out  32  misses started, wraps.

Behaviour:
- Address split: offset = fetch_addr[OFF_W-1:0]; index = next IDX_W bits; tag = the remaining upper bits.
- Reset values:
  - state IDLE; all valid bits 0.
  - fetch_data 0; mem_addr 0; hit_cnt 0; miss_cnt 0; flush_pend 0.
- hit (combinational) = state IDLE & fetch_en & valid[index] & tag match.
- fetch_stall (combinational) = (state != IDLE) | (fetch_en & ~hit).
- Hit: fetch_data is registered from line[index][offset] at the next edge (1-cycle latency, same as the memory). hit_cnt increments.
- fetch_en = 0: fetch_data holds its value.
- FSM states: IDLE and REFILL.
- IDLE, miss (fetch_en & ~hit):
  - latch base = {fetch_addr[29:OFF_W], OFF_W'b0}; req_cnt = 0; rsp_cnt = 0.
  - miss_cnt increments; go to REFILL.
- REFILL:
  - Request side: while req_cnt < LINE_WORDS, drive mem_addr = base + req_cnt and increment req_cnt.
  - Response side: from the second REFILL cycle on, write mem_data into line[index][rsp_cnt] and increment rsp_cnt.
  - After the write with rsp_cnt = LINE_WORDS-1: set tag[index]; set valid[index] = ~flush_pend; clear flush_pend; go to IDLE.
  - REFILL lasts exactly LINE_WORDS+1 cycles.
- Miss penalty:
  - Stall is high in the miss cycle plus all REFILL cycles, LINE_WORDS+2 cycles total.
  - The held fetch then hits in IDLE, and data appears on the following edge.
- Refilling a line overwrites the previous tag; the old line is lost (no write-back, read-only cache).
- flush in IDLE: all valid bits cleared at that edge. A hit in the same cycle still returns its data.
- flush during REFILL: set flush_pend. The refill completes, but the line is left invalid.
- flush while flush_pend is already set: no additional effect.
- Out-of-range addresses (upper bits nonzero): the memory returns 0. Cache them normally; no special case.
- rst mid-REFILL: abort immediately; all reset values apply; partial line data is don't-care because valid = 0.
- Counters wrap modulo 2^32. Hit and miss are mutually exclusive in a cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, REFILL);
  - OFF_W, IDX_W and TAG_W derived-width functions;
  - the INST_MEM_WORDS = 4096 constant.
- One natural sub-module, icache_line_store: the SETS x LINE_WORDS x 32 data array with one write port and one registered read port. The tag/valid arrays and the FSM stay in the top.

Test Plan (LINE_WORDS=4, SETS=16; mem[i] = 0x1000_0000 + i):
- Cold miss:
  - fetch_addr 0x000 after reset -> stall high 6 cycles; mem_addr sequence 0,1,2,3.
  - Then fetch_data = 0x1000_0000; miss_cnt = 1, hit_cnt = 1.
- Sequential hits:
  - fetch 1,2,3 back-to-back -> no stall; fetch_data 0x1000_0001..0x1000_0003, one per cycle; hit_cnt = 4.
- Conflict:
  - fetch 0x040 (index 0, new tag) -> 6-cycle refill from mem_addr 0x040..0x043.
  - Then fetch 0x000 -> miss again; miss_cnt = 3.
- Flush in IDLE:
  - pulse flush, then fetch 0x040 -> miss; refill re-executed.
- Flush mid-REFILL:
  - flush on REFILL cycle 2 -> refill completes and line stays invalid.
  - The held fetch misses again: a second 6-cycle stall.
- Reset mid-REFILL:
  - rst on REFILL cycle 3 -> next cycle: stall follows fetch_en only, counters 0, fetch_data 0.
  - A subsequent fetch 0x000 performs a full refill.
